// File: rtl/wb_burst_reader_if.sv
// wb_burst_reader_if: Wishbone read-master bus plus output stream between reader and its environment.
interface wb_burst_reader_if;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_ms;
   logic [31:0] wb_dat_sm;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic        wb_ack;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   modport master (
      output wb_adr, wb_dat_ms, wb_we, wb_cyc, wb_stb, wb_sel, wb_cti, wb_bte, m_data, m_valid,
      input  wb_dat_sm, wb_ack, m_ready
   );
   modport slave (
      input  wb_adr, wb_dat_ms, wb_we, wb_cyc, wb_stb, wb_sel, wb_cti, wb_bte, m_data, m_valid,
      output wb_dat_sm, wb_ack, m_ready
   );
endinterface

// File: rtl/wb_burst_reader.sv
// wb_burst_reader: reads nwords words over Wishbone incrementing bursts into a FWFT stream FIFO.
module wb_burst_reader #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [31:0]       base_adr_i,
   input  logic [15:0]       nwords_i,
   output logic              busy_o,
   output logic              done_o,
   wb_burst_reader_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(BURST_LEN) + 1;
   typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DRAIN} state_t;
   state_t        state_q, state_d;
   logic [31:0]   adr_q, adr_d;
   logic [15:0]   rem_q, rem_d;
   logic [LW-1:0] len_q, len_d, beat_q, beat_d;
   logic          done_q, done_d;
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic          push, pop, last_beat;
   logic [15:0]   burst_len, free_slots;

   assign push       = state_q == BURST && bus.wb_ack;
   assign pop        = bus.m_valid && bus.m_ready;
   assign burst_len  = rem_q < 16'(BURST_LEN) ? rem_q : 16'(BURST_LEN);
   assign free_slots = 16'(FIFO_DEPTH) - 16'(cnt_q);
   assign last_beat  = beat_q == len_q - 1'b1;

   assign bus.wb_adr    = adr_q;
   assign bus.wb_dat_ms = '0;
   assign bus.wb_we     = 1'b0;
   assign bus.wb_sel    = 4'hF;
   assign bus.wb_bte    = 2'b00;
   assign bus.m_data    = mem_q[rd_q];
   assign bus.m_valid   = cnt_q != '0;
   assign done_o        = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         rem_q   <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop);
         cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage is not reset: occupancy and pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= bus.wb_dat_sm;
      if (rst_n) assert (!(push && cnt_q == (AW+1)'(FIFO_DEPTH)));
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      rem_d   = rem_q;
      len_d   = len_q;
      beat_d  = beat_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            if (nwords_i == '0) done_d = 1'b1;
            else begin
               state_d = WAIT_SPACE;
               adr_d   = base_adr_i & 32'hFFFF_FFFC;
               rem_d   = nwords_i;
            end
         end
         // A burst is only issued once the FIFO can absorb all of it, so it never stalls mid-burst.
         WAIT_SPACE: if (free_slots >= burst_len) begin
            state_d = BURST;
            len_d   = LW'(burst_len);
            beat_d  = '0;
         end
         BURST: if (bus.wb_ack) begin
            adr_d  = adr_q + 32'd4;
            rem_d  = rem_q - 16'd1;
            beat_d = beat_q + 1'b1;
            if (last_beat) state_d = rem_q == 16'd1 ? DRAIN : WAIT_SPACE;
         end
         DRAIN: if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = state_q != IDLE;
      bus.wb_cyc = state_q == BURST;
      bus.wb_stb = state_q == BURST;
      bus.wb_cti = state_q != BURST ? 3'b000 : last_beat ? 3'b111 : 3'b010;
   end
endmodule

// File: tb/tb_wb_burst_reader.sv
// tb_wb_burst_reader: vector table of transfers plus hand sequences for stall, zero-length and reset cases.
module tb_wb_burst_reader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] base_adr_i;
   logic [15:0] nwords_i;
   logic        busy_o;
   logic        done_o;
   wb_burst_reader_if bus();

   wb_burst_reader #(.BURST_LEN(8), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_adr_i(base_adr_i),
      .nwords_i(nwords_i), .busy_o(busy_o), .done_o(done_o), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [15:0] n;
      bit          rnd;
      int          exp_bursts;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] adr_q[$];
   logic [2:0]  cti_q[$];
   logic [31:0] out_q[$];
   int          bursts, dones, busy_at_done, const_bad, idle_cti_bad;
   bit          wait_mode, cyc_prev;
   int          total = 0;
   int          passed = 0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hC3C3_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Slave and stream monitor: everything observed mid-cycle, ack driven for the next rising edge.
   always @(negedge clk) begin
      bit ack;
      if (bus.wb_cyc && !cyc_prev) bursts++;
      cyc_prev = bus.wb_cyc;
      if (done_o) begin
         dones++;
         if (busy_o) busy_at_done++;
      end
      if (bus.wb_we !== 1'b0 || bus.wb_sel !== 4'hF || bus.wb_bte !== 2'b00 || bus.wb_dat_ms !== 32'h0) const_bad++;
      if (!bus.wb_cyc && bus.wb_cti !== 3'b000) idle_cti_bad++;
      if (bus.m_valid && bus.m_ready) out_q.push_back(bus.m_data);
      ack = bus.wb_cyc && bus.wb_stb && (!wait_mode || $urandom_range(0, 2) != 0);
      bus.wb_ack = ack;
      bus.wb_dat_sm = ack ? pat(bus.wb_adr) : 32'hDEAD_BEEF;
      if (ack) begin
         adr_q.push_back(bus.wb_adr);
         cti_q.push_back(bus.wb_cti);
      end
   end

   task automatic clear_obs();
      adr_q.delete();
      cti_q.delete();
      out_q.delete();
      bursts = 0;
      dones = 0;
      busy_at_done = 0;
   endtask

   task automatic wait_done(input int limit);
      for (int c = 0; c < limit && dones == 0; c++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_data(input logic [31:0] base, input int n, input bit with_cti);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
         int bs = (i / 8) * 8;
         int len = (n - bs) < 8 ? (n - bs) : 8;
         if (i < adr_q.size()) chk($sformatf("adr[%0d]", i), adr_q[i], a);
         if (with_cti && i < cti_q.size()) chk($sformatf("cti[%0d]", i), 32'(cti_q[i]), i == bs + len - 1 ? 32'h7 : 32'h2);
         if (i < out_q.size()) chk($sformatf("data[%0d]", i), out_q[i], pat(a));
      end
   endtask

   task automatic run_vec(input vec_t v);
      clear_obs();
      wait_mode = v.rnd;
      bus.m_ready = 1'b1;
      start_i = 1'b1;
      base_adr_i = v.base;
      nwords_i = v.n;
      @(posedge clk);
      #1 start_i = 1'b0;
      wait_done(3000);
      repeat (4) @(posedge clk);
      #1;
      chk("beats", 32'(adr_q.size()), 32'(v.n));
      chk("words", 32'(out_q.size()), 32'(v.n));
      chk("bursts", 32'(bursts), 32'(v.exp_bursts));
      chk("done_count", 32'(dones), 32'd1);
      chk("busy_at_done", 32'(busy_at_done), 32'd0);
      chk("busy_after", 32'(busy_o), 32'd0);
      check_data(v.base, int'(v.n), 1'b1);
   endtask

   initial begin
      vecs[0] = '{base: 32'h0000_0100, n: 16'd8,  rnd: 1'b0, exp_bursts: 1};
      vecs[1] = '{base: 32'h0000_2000, n: 16'd20, rnd: 1'b0, exp_bursts: 3};
      vecs[2] = '{base: 32'hFFFF_FFF8, n: 16'd4,  rnd: 1'b1, exp_bursts: 1};
      vecs[3] = '{base: 32'h0000_0033, n: 16'd1,  rnd: 1'b0, exp_bursts: 1};
      vecs[4] = '{base: 32'h0000_0000, n: 16'd0,  rnd: 1'b0, exp_bursts: 0};
      vecs[5] = '{base: 32'h0000_0400, n: 16'd9,  rnd: 1'b1, exp_bursts: 2};
      rst_n = 1'b0;
      start_i = 1'b0;
      base_adr_i = '0;
      nwords_i = '0;
      bus.m_ready = 1'b0;
      bus.wb_ack = 1'b0;
      bus.wb_dat_sm = '0;
      wait_mode = 1'b0;
      cyc_prev = 1'b0;
      const_bad = 0;
      idle_cti_bad = 0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
      chk("rst_stb", 32'(bus.wb_stb), 32'd0);
      chk("rst_cti", 32'(bus.wb_cti), 32'd0);
      chk("rst_adr", bus.wb_adr, 32'd0);
      chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
      chk("rst_sel", 32'(bus.wb_sel), 32'hF);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 6; k++) run_vec(vecs[k]);

      // Wrapped address beat lands exactly on zero.
      clear_obs();
      run_vec(vecs[2]);
      if (adr_q.size() > 2) chk("wrap_adr2", adr_q[2], 32'h0);

      // Zero-length request: done the cycle after start, never busy, no bus cycle.
      clear_obs();
      start_i = 1'b1;
      nwords_i = 16'd0;
      base_adr_i = 32'h40;
      @(posedge clk);
      #1 start_i = 1'b0;
      chk("zero_done", 32'(done_o), 32'd1);
      chk("zero_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      chk("zero_done_once", 32'(done_o), 32'd0);
      chk("zero_cyc", 32'(bursts), 32'd0);

      // Stalled consumer: fetch stops at a full FIFO, then resumes.
      clear_obs();
      wait_mode = 1'b0;
      bus.m_ready = 1'b0;
      start_i = 1'b1;
      base_adr_i = 32'h800;
      nwords_i = 16'd32;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk("stall_beats", 32'(adr_q.size()), 32'd16);
      chk("stall_cyc", 32'(bus.wb_cyc), 32'd0);
      chk("stall_mvalid", 32'(bus.m_valid), 32'd1);
      chk("stall_busy", 32'(busy_o), 32'd1);
      bus.m_ready = 1'b1;
      wait_done(3000);
      repeat (3) @(posedge clk);
      #1;
      chk("stall_words", 32'(out_q.size()), 32'd32);
      chk("stall_bursts", 32'(bursts), 32'd4);
      chk("stall_done", 32'(dones), 32'd1);
      check_data(32'h800, 32, 1'b1);

      // Reset in the third beat drops the cycle and the buffered data silently.
      clear_obs();
      start_i = 1'b1;
      base_adr_i = 32'h500;
      nwords_i = 16'd8;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int c = 0; c < 50 && !bus.wb_cyc; c++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_cyc", 32'(bus.wb_cyc), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_cyc", 32'(bus.wb_cyc), 32'd0);
      chk("mid_rst_mvalid", 32'(bus.m_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_done", 32'(dones), 32'd0);
      run_vec('{base: 32'h600, n: 16'd5, rnd: 1'b0, exp_bursts: 1});

      chk("const_outputs", 32'(const_bad), 32'd0);
      chk("idle_cti", 32'(idle_cti_bad), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
